// File: rtl/waveram_dac_driver.sv
// Fetches one wave RAM sample per tick and ships it to a 16-bit SPI DAC
// as {command nibble, 12-bit code}, then pulses LDAC to update the output.
module waveram_dac_driver #(
    parameter int         CLK_DIV    = 2,
    parameter logic [3:0] DAC_CONFIG = 4'b0011
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_sample_tick,
    input  logic [12:0] i_waveram_address,
    output logic [12:0] o_ram_address,
    output logic        o_ram_read_enable,
    input  logic [11:0] i_ram_data,
    output logic        o_dac_cs_n,
    output logic        o_dac_sck,
    output logic        o_dac_sdi,
    output logic        o_dac_ldac_n,
    output logic        o_busy,
    output logic        o_sample_done,
    output logic        o_overrun,
    output logic [11:0] o_sample
);

    // state   | meaning
    // IDLE    | waiting for a sample tick
    // READ    | RAM read strobe asserted for one cycle
    // CAPTURE | RAM data valid; load frame, drop CS, present MSB
    // SHIFT   | 16 SCK periods, SDI updated on falling edges
    // CS_HIGH | CS released, CLK_DIV cycles before LDAC
    // LDAC    | LDAC low for CLK_DIV cycles; done pulses on the last one
    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        SHIFT,
        CS_HIGH,
        LDAC
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state;
    logic [7:0]  div_cnt;
    logic [3:0]  bit_cnt;
    logic [14:0] shift_reg;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state             <= IDLE;
            div_cnt           <= '0;
            bit_cnt           <= '0;
            shift_reg         <= '0;
            o_ram_address     <= '0;
            o_ram_read_enable <= 1'b0;
            o_dac_cs_n        <= 1'b1;
            o_dac_sck         <= 1'b0;
            o_dac_sdi         <= 1'b0;
            o_dac_ldac_n      <= 1'b1;
            o_busy            <= 1'b0;
            o_sample_done     <= 1'b0;
            o_overrun         <= 1'b0;
            o_sample          <= '0;
        end else begin
            o_overrun <= i_sample_tick && (state != IDLE);
            case (state)
                IDLE: begin
                    if (i_sample_tick) begin
                        o_ram_address     <= i_waveram_address;
                        o_ram_read_enable <= 1'b1;
                        o_busy            <= 1'b1;
                        state             <= READ;
                    end
                end
                READ: begin
                    o_ram_read_enable <= 1'b0;
                    state             <= CAPTURE;
                end
                CAPTURE: begin
                    // MSB goes straight to SDI, so only the remaining 15 bits are kept
                    shift_reg  <= {DAC_CONFIG[2:0], i_ram_data};
                    o_dac_sdi  <= DAC_CONFIG[3];
                    o_sample   <= i_ram_data;
                    o_dac_cs_n <= 1'b0;
                    o_dac_sck  <= 1'b0;
                    div_cnt    <= DIV_LAST;
                    bit_cnt    <= 4'd15;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        div_cnt <= DIV_LAST;
                        if (!o_dac_sck) begin
                            o_dac_sck <= 1'b1;
                        end else begin
                            o_dac_sck <= 1'b0;
                            if (bit_cnt == 4'd0) begin
                                o_dac_cs_n <= 1'b1;
                                o_dac_sdi  <= 1'b0;
                                state      <= CS_HIGH;
                            end else begin
                                bit_cnt   <= bit_cnt - 4'd1;
                                o_dac_sdi <= shift_reg[14];
                                shift_reg <= {shift_reg[13:0], 1'b0};
                            end
                        end
                    end
                end
                CS_HIGH: begin
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        o_dac_ldac_n  <= 1'b0;
                        div_cnt       <= DIV_LAST;
                        o_sample_done <= (CLK_DIV == 1);
                        state         <= LDAC;
                    end
                end
                LDAC: begin
                    // done is raised on the final LDAC cycle so a tick there counts as overrun
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                        if (div_cnt == 8'd1) o_sample_done <= 1'b1;
                    end else begin
                        o_dac_ldac_n  <= 1'b1;
                        o_busy        <= 1'b0;
                        o_sample_done <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_waveram_dac_driver.sv
// Bench for waveram_dac_driver: two instances (CLK_DIV=2 and CLK_DIV=1), a wave RAM
// model, and a bus monitor that decodes SPI frames and counts strobe cycles.
module tb_waveram_dac_driver;

    localparam logic [3:0] CFG = 4'b0011;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic        rst_n[2];
    logic        tick[2];
    logic [12:0] waddr[2];
    logic [12:0] ram_addr[2];
    logic        ram_re[2];
    logic [11:0] ram_data[2];
    logic        cs_n[2], sck[2], sdi[2], ldac_n[2], busy[2], done[2], ovr[2];
    logic [11:0] sample[2];

    logic [11:0] mem[8192];

    int          busy_tot[2] = '{0, 0};
    int          ldac_tot[2] = '{0, 0};
    int          re_tot[2]   = '{0, 0};
    int          done_tot[2] = '{0, 0};
    int          done_cyc[2] = '{0, 0};
    int          ovr_tot[2]  = '{0, 0};
    int          bits_tot[2] = '{0, 0};
    int          viol_tot[2] = '{0, 0};
    logic [15:0] frame[2]    = '{16'h0, 16'h0};
    logic        prev_sck[2] = '{1'b0, 1'b0};
    logic        prev_sdi[2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        waveram_dac_driver #(.CLK_DIV(g == 0 ? 2 : 1), .DAC_CONFIG(CFG)) u_dut (
            .i_clock           (clk),
            .i_reset           (rst_n[g]),
            .i_sample_tick     (tick[g]),
            .i_waveram_address (waddr[g]),
            .o_ram_address     (ram_addr[g]),
            .o_ram_read_enable (ram_re[g]),
            .i_ram_data        (ram_data[g]),
            .o_dac_cs_n        (cs_n[g]),
            .o_dac_sck         (sck[g]),
            .o_dac_sdi         (sdi[g]),
            .o_dac_ldac_n      (ldac_n[g]),
            .o_busy            (busy[g]),
            .o_sample_done     (done[g]),
            .o_overrun         (ovr[g]),
            .o_sample          (sample[g])
        );
    end

    // Synchronous-read RAM: data valid the cycle after the strobe
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (ram_re[i] === 1'b1) ram_data[i] <= mem[ram_addr[i]];
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (busy[i] === 1'b1) busy_tot[i] <= busy_tot[i] + 1;
            if (ldac_n[i] === 1'b0) ldac_tot[i] <= ldac_tot[i] + 1;
            if (ram_re[i] === 1'b1) re_tot[i] <= re_tot[i] + 1;
            if (done[i] === 1'b1) begin
                done_tot[i] <= done_tot[i] + 1;
                done_cyc[i] <= cyc;
            end
            if (ovr[i] === 1'b1) ovr_tot[i] <= ovr_tot[i] + 1;
            if (sck[i] === 1'b1 && prev_sck[i] === 1'b0) begin
                bits_tot[i] <= bits_tot[i] + 1;
                frame[i]    <= {frame[i][14:0], sdi[i]};
            end
            if ((cs_n[i] === 1'b1 && sck[i] === 1'b1) ||
                (sck[i] === 1'b1 && prev_sck[i] === 1'b1 && sdi[i] !== prev_sdi[i]))
                viol_tot[i] <= viol_tot[i] + 1;
            prev_sck[i] <= sck[i];
            prev_sdi[i] <= sdi[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One conversion on instance g. mid_off>0 injects an extra tick that many cycles
    // after the accepted one; carry_ovr is an overrun expected from the previous call.
    task automatic conv(input int g, input logic [12:0] addr, input int mid_off,
                        input int carry_ovr, input bit rel);
        int d, len, t0;
        int s_busy, s_ldac, s_re, s_done, s_ovr, s_bits, s_viol, exp_ovr;
        logic [11:0] data;
        d    = (g == 0) ? 2 : 1;
        len  = 2 + 34 * d;
        data = mem[addr];
        @(posedge clk); #1;
        if (rel) rst_n[g] = 1'b1;
        tick[g]  = 1'b1;
        waddr[g] = addr;
        t0       = cyc;
        s_busy = busy_tot[g]; s_ldac = ldac_tot[g]; s_re = re_tot[g]; s_done = done_tot[g];
        s_ovr  = ovr_tot[g];  s_bits = bits_tot[g]; s_viol = viol_tot[g];
        for (int k = 1; k <= len; k++) begin
            @(posedge clk); #1;
            if (k == 1) waddr[g] = 13'($urandom);
            tick[g] = (k == mid_off);
        end
        @(negedge clk); #1;
        exp_ovr = carry_ovr + ((mid_off > 0 && mid_off < len) ? 1 : 0);
        chk($sformatf("frame[%0d]", g),     frame[g], {CFG, data});
        chk($sformatf("bits[%0d]", g),      bits_tot[g] - s_bits, 16);
        chk($sformatf("sample[%0d]", g),    sample[g], data);
        chk($sformatf("ram_addr[%0d]", g),  ram_addr[g], addr);
        chk($sformatf("read_en[%0d]", g),   re_tot[g] - s_re, 1);
        chk($sformatf("busy_cyc[%0d]", g),  busy_tot[g] - s_busy, len);
        chk($sformatf("ldac_cyc[%0d]", g),  ldac_tot[g] - s_ldac, d);
        chk($sformatf("done_cnt[%0d]", g),  done_tot[g] - s_done, 1);
        chk($sformatf("done_at[%0d]", g),   done_cyc[g] - t0, len);
        chk($sformatf("overrun[%0d]", g),   ovr_tot[g] - s_ovr, exp_ovr);
        chk($sformatf("bus_viol[%0d]", g),  viol_tot[g] - s_viol, 0);
    endtask

    // Reset instance 0 while bit 7 is on the wire; the frame must die without LDAC
    task automatic abort_frame(input logic [12:0] addr);
        int s_bits, s_ldac, s_done;
        @(posedge clk); #1;
        tick[0]  = 1'b1;
        waddr[0] = addr;
        s_bits = bits_tot[0]; s_ldac = ldac_tot[0]; s_done = done_tot[0];
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            tick[0] = 1'b0;
            if (bits_tot[0] - s_bits >= 8) break;
        end
        chk("abort_bits", bits_tot[0] - s_bits, 8);
        #2;
        rst_n[0] = 1'b0;
        #1;
        chk("abort_cs_n",   cs_n[0], 1);
        chk("abort_sck",    sck[0], 0);
        chk("abort_busy",   busy[0], 0);
        chk("abort_ldac_n", ldac_n[0], 1);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_ldac", ldac_tot[0] - s_ldac, 0);
        chk("abort_no_done", done_tot[0] - s_done, 0);
    endtask

    initial begin
        rst_n = '{1'b0, 1'b0};
        tick  = '{1'b0, 1'b0};
        waddr = '{13'h0, 13'h0};
        for (int a = 0; a < 8192; a++) mem[a] = 12'($urandom);
        mem[13'h0ABC] = 12'h5A3;
        mem[13'h0DEF] = 12'hFFF;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_cs_n[%0d]", i),   cs_n[i], 1);
            chk($sformatf("rst_ldac_n[%0d]", i), ldac_n[i], 1);
            chk($sformatf("rst_sck[%0d]", i),    sck[i], 0);
            chk($sformatf("rst_sdi[%0d]", i),    sdi[i], 0);
            chk($sformatf("rst_re[%0d]", i),     ram_re[i], 0);
            chk($sformatf("rst_busy[%0d]", i),   busy[i], 0);
            chk($sformatf("rst_done[%0d]", i),   done[i], 0);
            chk($sformatf("rst_ovr[%0d]", i),    ovr[i], 0);
            chk($sformatf("rst_addr[%0d]", i),   ram_addr[i], 0);
            chk($sformatf("rst_sample[%0d]", i), sample[i], 0);
        end
        rst_n[1] = 1'b1;

        // Tick on the first edge after reset release, directed sample
        conv(0, 13'h0ABC, 0, 0, 1'b1);
        // Tick ten cycles into a frame
        conv(0, 13'($urandom), 10, 0, 1'b0);
        // Back-to-back frames, address extremes
        conv(0, 13'h0000, 0, 0, 1'b0);
        conv(0, 13'h0001, 0, 0, 1'b0);
        conv(0, 13'h1FFF, 0, 0, 1'b0);
        // Tick on the done cycle is an overrun; the very next cycle's tick is accepted
        conv(0, 13'($urandom), 70, 0, 1'b0);
        conv(0, 13'($urandom), 0, 1, 1'b0);
        for (int n = 0; n < 3; n++) conv(0, 13'($urandom), 0, 0, 1'b0);

        conv(1, 13'h0DEF, 0, 0, 1'b0);
        conv(1, 13'($urandom), 5, 0, 1'b0);
        for (int n = 0; n < 3; n++) conv(1, 13'($urandom), 0, 0, 1'b0);

        abort_frame(13'($urandom));
        conv(0, 13'($urandom), 0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
